// File: rtl/mac_seq_ctrl_pkg.sv
// Shared constants for the MAC job sequencer: default widths and FSM state codes.
package mac_seq_ctrl_pkg;

    localparam int unsigned MAC_N_DEF     = 18;
    localparam int unsigned MAC_LEN_W_DEF = 8;
    localparam int unsigned ST_W          = 3;

    localparam logic [ST_W-1:0] ST_IDLE  = 3'd0;
    localparam logic [ST_W-1:0] ST_CLEAR = 3'd1;
    localparam logic [ST_W-1:0] ST_RUN   = 3'd2;
    localparam logic [ST_W-1:0] ST_WAIT  = 3'd3;
    localparam logic [ST_W-1:0] ST_DONE  = 3'd4;

endpackage

// File: rtl/mac_len_cnt.sv
// Job-length counter: loads the job length, counts accepted pairs, flags the final pair.
module mac_len_cnt
    import mac_seq_ctrl_pkg::*;
#(
    parameter int unsigned LEN_W = MAC_LEN_W_DEF
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             clr,
    input  logic [LEN_W-1:0] len,
    input  logic             inc,
    output logic             last,
    output logic             len_zero
);

    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] count_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;

    // Next count / length: clr restarts a job and latches its length.
    always_comb begin
        count_d = count_q;
        len_d   = len_q;
        if (clr) begin
            count_d = '0;
            len_d   = len;
        end else if (inc) begin
            count_d = count_q + LEN_W'(1);
        end
    end

    // Counter and length registers.
    always_ff @(posedge clk) begin
        if (Rst) begin
            count_q <= '0;
            len_q   <= '0;
        end else begin
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    // The FSM leaves RUN on the last pair, so the count never needs to wrap.
    assign last     = (count_q == (len_q - LEN_W'(1)));
    assign len_zero = (len_q == '0);

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer for one dot-product job through an external MAC: clears it, streams
// operand pairs into it, then captures and presents the accumulator.
module mac_seq_ctrl
    import mac_seq_ctrl_pkg::*;
#(
    parameter int unsigned N     = MAC_N_DEF,
    parameter int unsigned LEN_W = MAC_LEN_W_DEF
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_w,
    input  logic [N-1:0]     in_x,
    output logic             mac_clr,
    output logic             mac_en,
    output logic [N-1:0]     mac_w,
    output logic [N-1:0]     mac_x,
    input  logic [2*N-1:0]   mac_acc,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [2*N-1:0]   res_data
);

    localparam int unsigned AW = 2 * N;

    logic [ST_W-1:0] state_q;
    logic [ST_W-1:0] state_d;
    logic [AW-1:0]   res_data_q;
    logic [AW-1:0]   res_data_d;
    logic            cnt_clr;
    logic            cnt_inc;
    logic            cnt_last;
    logic            cnt_len_zero;

    mac_len_cnt #(
        .LEN_W (LEN_W)
    ) u_len_cnt (
        .clk      (clk),
        .Rst      (Rst),
        .clr      (cnt_clr),
        .len      (len),
        .inc      (cnt_inc),
        .last     (cnt_last),
        .len_zero (cnt_len_zero)
    );

    // Next-state and output decode; Rst forces the quiescent output set.
    always_comb begin
        state_d    = state_q;
        res_data_d = res_data_q;
        cnt_clr    = 1'b0;
        cnt_inc    = 1'b0;
        busy       = (state_q != ST_IDLE);
        in_ready   = 1'b0;
        mac_clr    = 1'b0;
        mac_en     = 1'b0;
        mac_w      = '0;
        mac_x      = '0;
        res_valid  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cnt_clr = 1'b1;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                mac_clr = 1'b1;
                state_d = cnt_len_zero ? ST_WAIT : ST_RUN;
            end
            ST_RUN: begin
                in_ready = 1'b1;
                mac_w    = in_w;
                mac_x    = in_x;
                if (in_valid) begin
                    mac_en  = 1'b1;
                    cnt_inc = 1'b1;
                    if (cnt_last) begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                // Accumulator now includes the final product.
                res_data_d = mac_acc;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (Rst) begin
            busy     = 1'b0;
            in_ready = 1'b0;
            mac_clr  = 1'b1;
            mac_en   = 1'b0;
            mac_w    = '0;
            mac_x    = '0;
            res_valid = 1'b0;
            cnt_clr  = 1'b0;
            cnt_inc  = 1'b0;
        end
    end

    // State and result registers.
    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q    <= ST_IDLE;
            res_data_q <= '0;
        end else begin
            state_q    <= state_d;
            res_data_q <= res_data_d;
        end
    end

    assign res_data = res_data_q;

endmodule
